// File: rtl/ebu_gather_if.sv
// Valid/ready beat interface used on both sides of ebu_gather.
// last/keep exist only when EBU_GATHER_LAST_EN is defined.
interface ebu_gather_if #(
  parameter int unsigned Width = 8,
  parameter int unsigned Lanes = 1
);

  logic [Width-1:0] data;
  logic             valid;
  logic             ready;

  if (Width == 0 || Lanes == 0) begin : g_bad_param
    $error("ebu_gather_if: Width and Lanes must be non-zero");
  end

`ifdef EBU_GATHER_LAST_EN
  logic             last;
  logic [Lanes-1:0] keep;

  modport master (output data, valid, last, keep, input ready);
  modport slave  (input data, valid, last, keep, output ready);
`else
  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
`endif

endinterface

// File: rtl/ebu_gather.sv
// Elastic width up-converter: packs RATIO narrow beats into one registered wide word.
// Optional packet framing (t_0.last, i_0.last, i_0.keep) is enabled by EBU_GATHER_LAST_EN.
module ebu_gather #(
  parameter int unsigned T_0_WIDTH = 8,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned I_0_WIDTH = T_0_WIDTH * RATIO
) (
  input  logic         clk,
  input  logic         reset_n,
  ebu_gather_if.slave  t_0,
  ebu_gather_if.master i_0
);

  localparam int unsigned    CntW    = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RATIO - 1);

  if (RATIO < 2) begin : g_bad_ratio
    $error("ebu_gather: RATIO must be >= 2");
  end
  if (I_0_WIDTH != T_0_WIDTH * RATIO) begin : g_bad_width
    $error("ebu_gather: I_0_WIDTH must equal T_0_WIDTH*RATIO");
  end

  logic [CntW-1:0]                  r_cnt, w_cnt_nxt;
  logic [RATIO-2:0][T_0_WIDTH-1:0]  r_acc, w_acc_nxt;
  logic [I_0_WIDTH-1:0]             r_data, w_data_nxt;
  logic                             r_valid, w_valid_nxt;
  logic [RATIO-1:0][T_0_WIDTH-1:0]  w_word;
  logic                             w_complete;
  logic                             w_t_ready;
  logic                             w_t_acc;
  logic                             w_i_acc;

`ifdef EBU_GATHER_LAST_EN
  logic                             r_last, w_last_nxt;
  logic [RATIO-1:0]                 r_keep, w_keep_nxt, w_keep;
  logic [RATIO-1:0][T_0_WIDTH-1:0]  w_lanes;

  assign w_complete = (r_cnt == CntLast) | t_0.last;
  assign w_lanes    = {{T_0_WIDTH{1'b0}}, r_acc};

  // Short words: lanes below cnt come from acc, lane cnt is the live beat, the rest are zero.
  always_comb begin
    w_word = '0;
    w_keep = '0;
    for (int l = 0; l < RATIO; l++) begin
      if (CntW'(l) < r_cnt) begin
        w_word[l] = w_lanes[l];
      end else if (CntW'(l) == r_cnt) begin
        w_word[l] = t_0.data;
      end
      w_keep[l] = (CntW'(l) <= r_cnt);
    end
  end

  always_comb begin
    w_last_nxt = r_last;
    w_keep_nxt = r_keep;
    if (w_t_acc && w_complete) begin
      w_last_nxt = t_0.last;
      w_keep_nxt = w_keep;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b0;
      r_keep <= '0;
    end else begin
      r_last <= w_last_nxt;
      r_keep <= w_keep_nxt;
    end
  end

  assign i_0.last = r_last;
  assign i_0.keep = r_keep;
`else
  assign w_complete = (r_cnt == CntLast);
  assign w_word     = {t_0.data, r_acc};
`endif

  // The final beat may only land when the output register is free or draining this cycle.
  assign w_t_ready = ~w_complete | ~r_valid | i_0.ready;
  assign w_t_acc   = t_0.valid & w_t_ready;
  assign w_i_acc   = r_valid & i_0.ready;

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    if (w_t_acc && w_complete) begin
      w_data_nxt  = w_word;
      w_valid_nxt = 1'b1;
      w_cnt_nxt   = '0;
    end else begin
      if (w_t_acc) begin
        for (int l = 0; l < RATIO - 1; l++) begin
          if (r_cnt == CntW'(l)) begin
            w_acc_nxt[l] = t_0.data;
          end
        end
        w_cnt_nxt = r_cnt + 1'b1;
      end
      if (w_i_acc) begin
        w_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign t_0.ready = w_t_ready;
  assign i_0.data  = r_data;
  assign i_0.valid = r_valid;

endmodule

// File: tb/tb_ebu_gather.sv
// Bench for ebu_gather (T_0_WIDTH=8, RATIO=4): vector table, corner sequences, random scoreboard.
module tb_ebu_gather;

  localparam int unsigned TW = 8;
  localparam int unsigned R  = 4;
  localparam int unsigned IW = TW * R;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  ebu_gather_if #(.Width(TW), .Lanes(R)) t_if ();
  ebu_gather_if #(.Width(IW), .Lanes(R)) i_if ();

  ebu_gather #(
    .T_0_WIDTH(TW),
    .RATIO    (R),
    .I_0_WIDTH(IW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .t_0    (t_if.slave),
    .i_0    (i_if.master)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        tv;
    logic [7:0]  td;
    logic        ir;
    logic        exp_tr;
    logic        exp_ov;
    logic [31:0] exp_od;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    t_if.valid = 1'b0;
    t_if.data  = '0;
    i_if.ready = 1'b0;
`ifdef EBU_GATHER_LAST_EN
    t_if.last  = 1'b0;
    t_if.keep  = '1;
`endif
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  beats [$];
    logic [31:0] wexp;
    logic [31:0] prev_data;
    logic        prev_stall;
    logic        exp_v;
    logic        exp_r;
    int          acc_cnt;
    int          m_words;
    int          m_cons;
    int          cyc;

    // Test 1 then test 2, one row per cycle, starting from reset.
    vecs[0]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 32'h00000000};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h04030201};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h04030201};
    vecs[6]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h04030201};
    vecs[7]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h04030201};
    vecs[8]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 32'h04030201};
    vecs[9]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 32'h04030201};
    vecs[10] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 32'h04030201};
    vecs[11] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 32'h04030201};
    vecs[12] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 32'h04030201};
    vecs[13] = '{1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 32'h04030201};
    vecs[14] = '{1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 32'h04030201};
    vecs[15] = '{1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 32'h04030201};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h08070605};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h08070605};

    do_reset();
    @(negedge clk);
    check("reset_valid", 32'(i_if.valid), 32'd0);
    check("reset_data", i_if.data, 32'h0);
    check("reset_t_ready", 32'(t_if.ready), 32'd1);
    tick();

    for (int i = 0; i < 18; i++) begin
      t_if.valid = vecs[i].tv;
      t_if.data  = vecs[i].td;
      i_if.ready = vecs[i].ir;
      @(negedge clk);
      check($sformatf("tbl%0d_t_ready", i), 32'(t_if.ready), 32'(vecs[i].exp_tr));
      check($sformatf("tbl%0d_valid", i), 32'(i_if.valid), 32'(vecs[i].exp_ov));
      check($sformatf("tbl%0d_data", i), i_if.data, vecs[i].exp_od);
      tick();
    end

    // Test 3: sustained throughput, words on cycles 5, 9, 13.
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      t_if.valid = (c <= 12);
      t_if.data  = 8'(c - 1);
      i_if.ready = 1'b1;
      @(negedge clk);
      if (c <= 12) check($sformatf("thr_t_ready_c%0d", c), 32'(t_if.ready), 32'd1);
      exp_v = (c == 5) || (c == 9) || (c == 13);
      check($sformatf("thr_valid_c%0d", c), 32'(i_if.valid), 32'(exp_v));
      if (exp_v) begin
        wexp = {8'(c - 2), 8'(c - 3), 8'(c - 4), 8'(c - 5)};
        check($sformatf("thr_data_c%0d", c), i_if.data, wexp);
      end
      tick();
    end

    // Test 4: asynchronous reset with a held word and a partial word in flight.
    do_reset();
    i_if.ready = 1'b0;
    t_if.valid = 1'b1;
    for (int b = 0; b < 6; b++) begin
      t_if.data = (b == 4) ? 8'h11 : (b == 5) ? 8'h22 : 8'(8'h55 + b);
      tick();
    end
    idle();
    @(negedge clk);
    check("arst_pre_valid", 32'(i_if.valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(i_if.valid), 32'd0);
    check("arst_data", i_if.data, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    i_if.ready = 1'b1;
    t_if.valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      t_if.data = 8'(8'hA1 + b);
      tick();
    end
    t_if.valid = 1'b0;
    @(negedge clk);
    check("arst_after_valid", 32'(i_if.valid), 32'd1);
    check("arst_after_data", i_if.data, 32'hA4A3A2A1);
    tick();

`ifdef EBU_GATHER_LAST_EN
    // Test 6: short packet, then a full word.
    do_reset();
    i_if.ready = 1'b1;
    t_if.valid = 1'b1;
    t_if.data  = 8'h01;
    tick();
    t_if.data  = 8'h02;
    t_if.last  = 1'b1;
    tick();
    idle();
    i_if.ready = 1'b1;
    @(negedge clk);
    check("last_short_data", i_if.data, 32'h00000201);
    check("last_short_keep", 32'(i_if.keep), 32'h3);
    check("last_short_last", 32'(i_if.last), 32'd1);
    tick();
    t_if.valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      t_if.data = 8'(8'h05 + b);
      tick();
    end
    t_if.valid = 1'b0;
    @(negedge clk);
    check("last_full_data", i_if.data, 32'h08070605);
    check("last_full_keep", 32'(i_if.keep), 32'hF);
    check("last_full_last", 32'(i_if.last), 32'd0);
    tick();
`endif

    // Test 5: random traffic against a beat-queue model.
    do_reset();
    acc_cnt    = 0;
    m_words    = 0;
    m_cons     = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (m_cons < 250 && cyc < 20000 && bad < 50) begin
      t_if.valid = (acc_cnt < 1000) && ($urandom_range(0, 1) == 1);
      t_if.data  = 8'($urandom);
      i_if.ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      exp_v = (m_words > m_cons);
      exp_r = ((acc_cnt % 4) != 3) || !exp_v || i_if.ready;
      check("rnd_valid", 32'(i_if.valid), 32'(exp_v));
      check("rnd_t_ready", 32'(t_if.ready), 32'(exp_r));
      if (prev_stall) check("rnd_hold", i_if.data, prev_data);
      if (exp_v && i_if.ready) begin
        wexp = {beats[4*m_cons+3], beats[4*m_cons+2], beats[4*m_cons+1], beats[4*m_cons]};
        check("rnd_word", i_if.data, wexp);
        m_cons++;
      end
      if (t_if.valid && exp_r) begin
        beats.push_back(t_if.data);
        acc_cnt++;
        if (acc_cnt % 4 == 0) m_words++;
      end
      prev_stall = exp_v && !i_if.ready;
      prev_data  = i_if.data;
      tick();
      cyc++;
    end
    check("rnd_words_done", 32'(m_cons), 32'd250);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
